register_file_2r1w: RTL and testbench
=====================================

// Module: register_file_2r1w
// PURPOSE
//  32-entry integer register file for the single-cycle RISC-V core, built from
//  per-register flip-flop storage with one write port and two read ports.
//  Sits between decode (rs1/rs2/rd) and the ALU/write-back mux.
//  Reads are combinational; the write-back result is committed on the qualified
//  rising Clock edge.
// PARAMETERS
//  NrOfBits     32           data width of each register
//  NrOfAddrBits 5            address width; entry count = 2**NrOfAddrBits
//  Bypass       1            1: read of the register being written returns WriteData
//  SpInit       32'h00003FFC x2 (sp) value loaded on reset; all others load 0
// PORTS
//  Clock       in  1             single clock, rising edge active
//  Reset       in  1             synchronous, active-low; 0 at a rising edge = reset
//  ClockEnable in  1             global enable; write happens only if ClockEnable&Tick
//  Tick        in  1             clock-divider tick qualifier
//  WriteEnable in  1             RegWrite from control
//  WriteAddr   in  NrOfAddrBits  rd
//  WriteData   in  NrOfBits      write-back value
//  ReadAddrA   in  NrOfAddrBits  rs1
//  ReadAddrB   in  NrOfAddrBits  rs2
//  ReadDataA   out NrOfBits      value of rs1
//  ReadDataB   out NrOfBits      value of rs2
// BEHAVIOUR
//  - Reset: one Clock, one synchronous active-low Reset. Reset is sampled only at
//    a rising Clock edge and overrides ClockEnable, Tick and WriteEnable.
//    While Reset=0 at an edge, every entry loads 0, except x2, which loads SpInit.
//    Reset outputs: ReadDataA/B show the addressed entry; after reset this is 0,
//    or SpInit for address 2.
//  - Write commit: at a rising edge, if Reset=1 and ClockEnable&Tick&WriteEnable
//    and WriteAddr!=0, then reg[WriteAddr] <= WriteData. Otherwise there is no change.
//  - x0: never stored. Reads of address 0 return 0 in every case, including
//    bypass while WriteAddr=0.
//  - Read: ReadDataX = reg[ReadAddrX], combinational, with zero-cycle latency.
//  - Bypass=1: if WriteEnable&ClockEnable&Tick&Reset and WriteAddr==ReadAddrX!=0,
//    then ReadDataX=WriteData in the same cycle.
//    Bypass=0: ReadDataX shows the old value until after the edge.
//  - A and B are independent. Both may address the same register, and both may
//    equal WriteAddr; each then applies the rules above.
//  - Tick=0 or ClockEnable=0 holds all state; read ports remain live.
//  - If Reset is deasserted mid-stream, the first qualified write takes effect
//    at the first edge with Reset=1.
//  - There are no X-propagation paths. Out-of-range addresses cannot occur,
//    because the entry count is exactly 2**NrOfAddrBits.
// TESTING
//  1. Hold Reset=0 for 2 edges, then release.
//     -> Read of x2 = 32'h00003FFC; reads of x1, x5 and x31 = 0.
//  2. Write x5=32'hDEADBEEF with CE=Tick=WE=1, then read A=5, B=5 next cycle.
//     -> Both ports = DEADBEEF.
//  3. Write x0=32'hFFFFFFFF, then read A=0.
//     -> 0. With Bypass=1, A=0 during the write cycle -> 0.
//  4. Write x7=32'h12345678 with Tick=0 for 3 edges, then Tick=1 for 1 edge.
//     -> x7 reads old value (0) until after the Tick edge, then 12345678.
//  5. Bypass=1: in the same cycle, WriteAddr=ReadAddrA=9 and WriteData=32'hA5A5A5A5.
//     -> ReadDataA=A5A5A5A5 before the edge. Bypass=0 -> old value before the edge.
//  6. Write x3=32'h55 with WE=1 and Reset=0 at the same edge.
//     -> x3=0 after the edge; the reset wins.

Source files
------------

// File: rtl/register_file_2r1w_if.sv
// Decode/write-back bus of the 2-read/1-write register file.
// master = core side driving addresses and write-back, slave = register file.
interface register_file_2r1w_if #(
    parameter int NrOfBits     = 32,
    parameter int NrOfAddrBits = 5
);
    logic                    ClockEnable;
    logic                    Tick;
    logic                    WriteEnable;
    logic [NrOfAddrBits-1:0] WriteAddr;
    logic [NrOfBits-1:0]     WriteData;
    logic [NrOfAddrBits-1:0] ReadAddrA;
    logic [NrOfAddrBits-1:0] ReadAddrB;
    logic [NrOfBits-1:0]     ReadDataA;
    logic [NrOfBits-1:0]     ReadDataB;

    modport master (
        output ClockEnable, Tick, WriteEnable, WriteAddr, WriteData, ReadAddrA, ReadAddrB,
        input  ReadDataA, ReadDataB
    );

    modport slave (
        input  ClockEnable, Tick, WriteEnable, WriteAddr, WriteData, ReadAddrA, ReadAddrB,
        output ReadDataA, ReadDataB
    );
endinterface

// File: rtl/register_file_2r1w.sv
// 32-entry RISC-V integer register file: flop-per-register storage, one
// qualified write port, two combinational read ports with optional write bypass.

module register_file_2r1w_entry #(
    parameter int           W      = 32,
    parameter logic [W-1:0] RstVal = '0
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         we_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] q_d, q_q;

    always_comb begin
        q_d = q_q;
        if (we_i) q_d = d_i;
    end

    always_ff @(posedge Clock) begin
        if (!Reset) q_q <= RstVal;
        else        q_q <= q_d;
    end

    assign q_o = q_q;
endmodule

module register_file_2r1w #(
    parameter int                   NrOfBits     = 32,
    parameter int                   NrOfAddrBits = 5,
    parameter bit                   Bypass       = 1'b1,
    parameter logic [NrOfBits-1:0]  SpInit       = 32'h0000_3FFC
) (
    input  logic                 Clock,
    input  logic                 Reset,
    register_file_2r1w_if.slave  bus
);
    localparam int NrEntries = 2 ** NrOfAddrBits;

    logic [NrEntries-1:0][NrOfBits-1:0] regs_q;
    logic                               wr_qual;
    logic [NrOfBits-1:0]                rd_a, rd_b;

    // Reset is folded in so the bypass never forwards a write that reset will discard.
    assign wr_qual = Reset & bus.ClockEnable & bus.Tick & bus.WriteEnable;

    assign regs_q[0] = '0;

    for (genvar i = 1; i < NrEntries; i++) begin : g_entry
        register_file_2r1w_entry #(
            .W      (NrOfBits),
            .RstVal ((i == 2) ? SpInit : '0)
        ) u_entry (
            .Clock (Clock),
            .Reset (Reset),
            .we_i  (wr_qual && (bus.WriteAddr == NrOfAddrBits'(i))),
            .d_i   (bus.WriteData),
            .q_o   (regs_q[i])
        );
    end

    always_comb begin
        rd_a = regs_q[bus.ReadAddrA];
        rd_b = regs_q[bus.ReadAddrB];
        if (Bypass && wr_qual && (bus.WriteAddr == bus.ReadAddrA)) rd_a = bus.WriteData;
        if (Bypass && wr_qual && (bus.WriteAddr == bus.ReadAddrB)) rd_b = bus.WriteData;
        // x0 is hard-wired, even against a bypassed write to address 0.
        if (bus.ReadAddrA == '0) rd_a = '0;
        if (bus.ReadAddrB == '0) rd_b = '0;
    end

    assign bus.ReadDataA = rd_a;
    assign bus.ReadDataB = rd_b;
endmodule

// File: tb/tb_register_file_2r1w.sv
// Scoreboard bench: a driver pushes expected read values computed from an
// array model, a negedge monitor pops and compares both bypass variants.
module tb_register_file_2r1w;
    localparam logic [31:0] SP = 32'h0000_3FFC;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    register_file_2r1w_if #(.NrOfBits(32), .NrOfAddrBits(5)) bus1 ();
    register_file_2r1w_if #(.NrOfBits(32), .NrOfAddrBits(5)) bus0 ();

    register_file_2r1w #(.Bypass(1'b1), .SpInit(SP)) dut_byp (
        .Clock(Clock), .Reset(Reset), .bus(bus1)
    );
    register_file_2r1w #(.Bypass(1'b0), .SpInit(SP)) dut_nobyp (
        .Clock(Clock), .Reset(Reset), .bus(bus0)
    );

    typedef struct {
        logic [31:0] a1, b1, a0, b0;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    logic [31:0] mdl [32];
    bit          mdl_ok = 0;

    // inputs currently applied, committed into the model at the next edge
    logic        c_rst, c_ce, c_tick, c_we;
    logic [4:0]  c_wa, c_ra, c_rb;
    logic [31:0] c_wd;

    function automatic logic [31:0] expect_rd(input logic [4:0] ra, input bit byp);
        if (ra == 0) return 32'h0;
        if (byp && c_rst && c_ce && c_tick && c_we && c_wa == ra) return c_wd;
        return mdl[ra];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic ce, input logic tick, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] ra, input logic [4:0] rb, input string tag);
        exp_t e;
        @(posedge Clock);
        if (!c_rst) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
            mdl[2] = SP;
            mdl_ok = 1;
        end else if (c_ce && c_tick && c_we && c_wa != 0) begin
            mdl[c_wa] = c_wd;
        end
        #1;
        c_rst = rst; c_ce = ce; c_tick = tick; c_we = we;
        c_wa = wa; c_wd = wd; c_ra = ra; c_rb = rb;
        Reset = rst;
        bus1.ClockEnable = ce; bus1.Tick = tick; bus1.WriteEnable = we;
        bus1.WriteAddr = wa; bus1.WriteData = wd; bus1.ReadAddrA = ra; bus1.ReadAddrB = rb;
        bus0.ClockEnable = ce; bus0.Tick = tick; bus0.WriteEnable = we;
        bus0.WriteAddr = wa; bus0.WriteData = wd; bus0.ReadAddrA = ra; bus0.ReadAddrB = rb;
        if (mdl_ok) begin
            e.a1 = expect_rd(ra, 1'b1); e.b1 = expect_rd(rb, 1'b1);
            e.a0 = expect_rd(ra, 1'b0); e.b0 = expect_rd(rb, 1'b0);
            e.tag = tag;
            sb.push_back(e);
        end
    endtask

    // monitor: reads are combinational, so the outputs are valid every negedge
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check({e.tag, ".A.byp"},   bus1.ReadDataA, e.a1);
                check({e.tag, ".B.byp"},   bus1.ReadDataB, e.b1);
                check({e.tag, ".A.nobyp"}, bus0.ReadDataA, e.a0);
                check({e.tag, ".B.nobyp"}, bus0.ReadDataB, e.b0);
            end
        end
    end

    initial begin
        logic [4:0] wa, ra, rb;
        c_rst = 0; c_ce = 0; c_tick = 0; c_we = 0;
        c_wa = 0; c_wd = 0; c_ra = 0; c_rb = 0;
        Reset = 0;
        bus1.ClockEnable = 0; bus1.Tick = 0; bus1.WriteEnable = 0; bus1.WriteAddr = 0;
        bus1.WriteData = 0; bus1.ReadAddrA = 0; bus1.ReadAddrB = 0;
        bus0.ClockEnable = 0; bus0.Tick = 0; bus0.WriteEnable = 0; bus0.WriteAddr = 0;
        bus0.WriteData = 0; bus0.ReadAddrA = 0; bus0.ReadAddrB = 0;

        // reset for two edges, then check sp and a few zeros
        step(0, 1, 1, 0, 0, 0, 2, 1, "rst");
        step(0, 1, 1, 0, 0, 0, 2, 1, "rst");
        step(1, 1, 1, 0, 0, 0, 2, 1, "rst_sp_x1");
        step(1, 1, 1, 0, 0, 0, 5, 31, "rst_x5_x31");

        // plain write then read both ports
        step(1, 1, 1, 1, 5, 32'hDEADBEEF, 5, 5, "wr_x5");
        step(1, 1, 1, 0, 0, 0, 5, 5, "rd_x5");

        // x0 is never stored nor bypassed
        step(1, 1, 1, 1, 0, 32'hFFFFFFFF, 0, 0, "wr_x0");
        step(1, 1, 1, 0, 0, 0, 0, 5, "rd_x0");

        // Tick gating holds state
        step(1, 1, 0, 1, 7, 32'h12345678, 7, 7, "tick0_a");
        step(1, 1, 0, 1, 7, 32'h12345678, 7, 7, "tick0_b");
        step(1, 1, 0, 1, 7, 32'h12345678, 7, 7, "tick0_c");
        step(1, 1, 1, 1, 7, 32'h12345678, 7, 0, "tick1");
        step(1, 1, 1, 0, 0, 0, 7, 7, "rd_x7");

        // ClockEnable gating
        step(1, 0, 1, 1, 7, 32'hCAFEF00D, 7, 7, "ce0");
        step(1, 1, 1, 0, 0, 0, 7, 7, "rd_x7_ce");

        // bypass: both ports on the written register
        step(1, 1, 1, 1, 9, 32'hA5A5A5A5, 9, 9, "byp_x9");
        step(1, 1, 1, 0, 0, 0, 9, 2, "rd_x9");

        // reset wins over a write at the same edge
        step(1, 1, 1, 1, 3, 32'h55, 3, 3, "wr_x3");
        step(0, 1, 1, 1, 3, 32'h77, 3, 2, "rst_wr_x3");
        step(1, 1, 1, 0, 0, 0, 3, 5, "rd_x3_after_rst");

        // randomized traffic with occasional reset and gating
        for (int n = 0; n < 600; n++) begin
            wa = 5'($urandom_range(0, 31));
            ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                 wa, $urandom, ra, rb, "rand");
        end

        step(1, 0, 0, 0, 0, 0, 0, 0, "idle");
        @(negedge Clock);
        @(negedge Clock);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
